// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code to ASCII controller: tracks prefixes, shift and caps-lock,
// drives a registered lookup table and hands characters out over a
// valid/ready interface.
module ps2_key_ctrl (
    input  logic       clk,
    input  logic       clrn,
    input  logic       code_valid,
    input  logic [7:0] code_in,
    output logic       code_ready,
    output logic [7:0] lut_code,
    output logic       lut_shift,
    input  logic [7:0] lut_ascii,
    output logic       key_valid,
    output logic [7:0] key_ascii,
    input  logic       key_ready,
    output logic       shift_st,
    output logic       caps_st,
    output logic [7:0] key_count
);

    localparam logic [7:0] C_EXT   = 8'hE0;
    localparam logic [7:0] C_BRK   = 8'hF0;
    localparam logic [7:0] C_LSH   = 8'h12;
    localparam logic [7:0] C_RSH   = 8'h59;
    localparam logic [7:0] C_CAPS  = 8'h58;
    localparam logic [7:0] C_UNMAP = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        BRK,
        EXT,
        EXTBRK,
        LK1,
        LK2,
        HOLD
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_lshift;
    logic       r_rshift;
    logic       r_caps;
    logic       r_caps_held;
    logic [7:0] r_lut_code;
    logic       r_lut_shift;
    logic       r_key_valid;
    logic [7:0] r_key_ascii;
    logic [7:0] r_key_count;

    logic       w_code_ready;
    logic       w_xfer;
    logic       w_shift;
    logic       w_lshift_set;
    logic       w_lshift_clr;
    logic       w_rshift_set;
    logic       w_rshift_clr;
    logic       w_caps_make;
    logic       w_caps_brk;
    logic       w_lut_load;
    logic       w_key_load;
    logic       w_key_take;

    // Swap letter case when caps-lock is on; non-letters pass unchanged.
    function automatic logic [7:0] case_fix(input logic [7:0] a, input logic caps);
        logic [7:0] r;
        r = a;
        if (caps) begin
            if (a >= 8'h61 && a <= 8'h7A)
                r = a - 8'h20;
            else if (a >= 8'h41 && a <= 8'h5A)
                r = a + 8'h20;
        end
        return r;
    endfunction

    assign w_code_ready = (r_state == IDLE) || (r_state == BRK) ||
                          (r_state == EXT)  || (r_state == EXTBRK);
    assign w_xfer       = code_valid && w_code_ready;
    assign w_shift      = r_lshift || r_rshift;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and per-cycle action decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_lshift_set = 1'b0;
        w_lshift_clr = 1'b0;
        w_rshift_set = 1'b0;
        w_rshift_clr = 1'b0;
        w_caps_make  = 1'b0;
        w_caps_brk   = 1'b0;
        w_lut_load   = 1'b0;
        w_key_load   = 1'b0;
        w_key_take   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (code_in == C_EXT)       w_state_nxt = EXT;
                    else if (code_in == C_BRK)  w_state_nxt = BRK;
                    else if (code_in == C_LSH)  w_lshift_set = 1'b1;
                    else if (code_in == C_RSH)  w_rshift_set = 1'b1;
                    else if (code_in == C_CAPS) w_caps_make = 1'b1;
                    else begin
                        w_lut_load  = 1'b1;
                        w_state_nxt = LK1;
                    end
                end
            end
            BRK: begin
                if (w_xfer) begin
                    w_lshift_clr = (code_in == C_LSH);
                    w_rshift_clr = (code_in == C_RSH);
                    w_caps_brk   = (code_in == C_CAPS);
                    w_state_nxt  = IDLE;
                end
            end
            EXT: begin
                if (w_xfer)
                    w_state_nxt = (code_in == C_BRK) ? EXTBRK : IDLE;
            end
            EXTBRK: begin
                if (w_xfer)
                    w_state_nxt = IDLE;
            end
            LK1: w_state_nxt = LK2;
            LK2: begin
                if (lut_ascii == C_UNMAP) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_key_load  = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (key_ready) begin
                    w_key_take  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Modifier tracking, lookup request and character/count registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_lut_code  <= '0;
            r_lut_shift <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_ascii <= '0;
            r_key_count <= '0;
        end else begin
            if (w_lshift_set)      r_lshift <= 1'b1;
            else if (w_lshift_clr) r_lshift <= 1'b0;
            if (w_rshift_set)      r_rshift <= 1'b1;
            else if (w_rshift_clr) r_rshift <= 1'b0;
            if (w_caps_make) begin
                if (!r_caps_held) r_caps <= ~r_caps;
                r_caps_held <= 1'b1;
            end else if (w_caps_brk) begin
                r_caps_held <= 1'b0;
            end
            if (w_lut_load) begin
                r_lut_code  <= code_in;
                r_lut_shift <= w_shift;
            end
            if (w_key_load) begin
                r_key_ascii <= case_fix(lut_ascii, r_caps);
                r_key_valid <= 1'b1;
            end else if (w_key_take) begin
                r_key_valid <= 1'b0;
                r_key_count <= r_key_count + 8'd1;
            end
        end
    end

    assign code_ready = w_code_ready;
    assign lut_code   = r_lut_code;
    assign lut_shift  = r_lut_shift;
    assign key_valid  = r_key_valid;
    assign key_ascii  = r_key_ascii;
    assign shift_st   = w_shift;
    assign caps_st    = r_caps;
    assign key_count  = r_key_count;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: a behavioural registered LUT,
// a scoreboard of expected characters and a delivery monitor.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       clrn;
    logic       code_valid;
    logic [7:0] code_in;
    logic       code_ready;
    logic [7:0] lut_code;
    logic       lut_shift;
    logic [7:0] lut_ascii = 8'hFF;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_ready;
    logic       shift_st;
    logic       caps_st;
    logic [7:0] key_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  sb[$];
    logic [7:0]  m_cnt = 8'h00;

    ps2_key_ctrl dut (
        .clk        (clk),
        .clrn       (clrn),
        .code_valid (code_valid),
        .code_in    (code_in),
        .code_ready (code_ready),
        .lut_code   (lut_code),
        .lut_shift  (lut_shift),
        .lut_ascii  (lut_ascii),
        .key_valid  (key_valid),
        .key_ascii  (key_ascii),
        .key_ready  (key_ready),
        .shift_st   (shift_st),
        .caps_st    (caps_st),
        .key_count  (key_count)
    );

    always #5 clk = ~clk;

    // Small scan-code table: unshifted / shifted characters, FF otherwise.
    function automatic logic [7:0] lut_fn(input logic [7:0] c, input logic s);
        case (c)
            8'h1C:   return s ? 8'h41 : 8'h61;
            8'h15:   return s ? 8'h51 : 8'h71;
            8'h16:   return s ? 8'h21 : 8'h31;
            8'h1E:   return s ? 8'h40 : 8'h32;
            8'h32:   return s ? 8'h42 : 8'h62;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] fix(input logic [7:0] a, input logic caps);
        if (caps && a >= 8'h61 && a <= 8'h7A) return a - 8'h20;
        if (caps && a >= 8'h41 && a <= 8'h5A) return a + 8'h20;
        return a;
    endfunction

    // Registered lookup table with one cycle of latency.
    always @(posedge clk) lut_ascii <= lut_fn(lut_code, lut_shift);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Delivery monitor: a handshake seen before the edge pops the scoreboard.
    always @(negedge clk) begin
        if (clrn && key_valid && key_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_char", {24'h0, key_ascii}, 32'h100);
            end else begin
                check("ascii", {24'h0, key_ascii}, {24'h0, sb.pop_front()});
            end
            m_cnt = m_cnt + 8'd1;
        end
    end

    // Drive one byte; returns #1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        code_valid = 1'b1;
        code_in    = b;
        n = 0;
        @(negedge clk);
        while (!code_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    // Make code of a character key; the expected result is queued when mapped.
    task automatic send_make(input logic [7:0] c, input logic s, input logic caps);
        logic [7:0] e;
        e = lut_fn(c, s);
        if (e != 8'hFF) sb.push_back(fix(e, caps));
        send_byte(c);
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic s, input logic c);
        @(negedge clk);
        check({tag, "_shift"}, {31'h0, shift_st}, {31'h0, s});
        check({tag, "_caps"},  {31'h0, caps_st},  {31'h0, c});
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn       = 1'b0;
        code_valid = 1'b0;
        code_in    = 8'h00;
        key_ready  = 1'b1;
        #23;
        check("rst_valid", {31'h0, key_valid}, 32'h0);
        check("rst_ascii", {24'h0, key_ascii}, 32'h0);
        check("rst_lut_code", {24'h0, lut_code}, 32'h0);
        check("rst_count", {24'h0, key_count}, 32'h0);
        check("rst_status", {30'h0, shift_st, caps_st}, 32'h0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", {31'h0, code_ready}, 32'h1);

        // Basic make/break with latency check.
        send_make(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_e0", {31'h0, key_valid}, 32'h0);
        @(negedge clk);
        check("lat_e1", {31'h0, key_valid}, 32'h0);
        @(negedge clk);
        check("lat_e2", {31'h0, key_valid}, 32'h1);
        @(posedge clk);
        #1;
        send_byte(8'hF0);
        send_byte(8'h1C);
        idle_cycles(2);
        check("cnt_basic", {24'h0, key_count}, 32'h1);

        // Shift.
        send_byte(8'h12);
        check_status("sh_held", 1'b1, 1'b0);
        send_make(8'h16, 1'b1, 1'b0);
        send_byte(8'hF0); send_byte(8'h16);
        check_status("sh_still", 1'b1, 1'b0);
        send_byte(8'hF0); send_byte(8'h12);
        check_status("sh_rel", 1'b0, 1'b0);
        send_byte(8'h59);
        check_status("rsh_held", 1'b1, 1'b0);
        send_make(8'h1C, 1'b1, 1'b0);
        send_byte(8'hF0); send_byte(8'h59);
        check_status("rsh_rel", 1'b0, 1'b0);

        // Caps with typematic repeats of the caps key.
        send_byte(8'h58); send_byte(8'h58); send_byte(8'h58);
        check_status("caps_rep", 1'b0, 1'b1);
        send_byte(8'hF0); send_byte(8'h58);
        send_make(8'h15, 1'b0, 1'b1);
        send_byte(8'hF0); send_byte(8'h15);
        send_byte(8'h12);
        send_make(8'h15, 1'b1, 1'b1);
        send_make(8'h16, 1'b1, 1'b1);
        send_byte(8'hF0); send_byte(8'h12);
        send_make(8'h1E, 1'b0, 1'b1);
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        check_status("caps_off", 1'b0, 1'b0);

        // Typematic repeat of a character key.
        send_make(8'h32, 1'b0, 1'b0);
        send_make(8'h32, 1'b0, 1'b0);
        send_byte(8'hF0); send_byte(8'h32);

        // Backpressure.
        idle_cycles(4);
        key_ready = 1'b0;
        send_make(8'h1C, 1'b0, 1'b0);
        idle_cycles(3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, key_valid}, 32'h1);
            check("bp_ascii", {24'h0, key_ascii}, 32'h61);
            check("bp_ready", {31'h0, code_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        key_ready = 1'b1;
        idle_cycles(1);
        @(negedge clk);
        check("bp_once", {31'h0, key_valid}, 32'h0);
        @(posedge clk);
        #1;

        // Unmapped code.
        send_make(8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("unmapped", {31'h0, key_valid}, 32'h0);
        end
        @(posedge clk);
        #1;

        // Extended sequences while shift is held.
        send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'h58);
        check_status("ext", 1'b1, 1'b0);
        send_byte(8'hF0); send_byte(8'h12);
        idle_cycles(4);
        check("sb_drained", sb.size(), 0);
        check("cnt_model", {24'h0, key_count}, {24'h0, m_cnt});

        // Reset during LK2 with shift and caps active.
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        send_byte(8'h12);
        send_byte(8'h1C);
        @(posedge clk);
        #1;
        clrn = 1'b0;
        #2;
        check("rstl_valid", {31'h0, key_valid}, 32'h0);
        check("rstl_count", {24'h0, key_count}, 32'h0);
        check("rstl_status", {30'h0, shift_st, caps_st}, 32'h0);
        check("rstl_lut", {23'h0, lut_code, lut_shift}, 32'h0);
        m_cnt = 8'h00;
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstl_nochar", {31'h0, key_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        check("rstl_cnt_after", {24'h0, key_count}, 32'h0);

        // 256 deliveries wrap the counter.
        for (int i = 0; i < 256; i++) begin
            send_make(8'h1C, 1'b0, 1'b0);
            if (i == 254) begin
                idle_cycles(5);
                check("cnt_255", {24'h0, key_count}, 32'hFF);
            end
        end
        idle_cycles(5);
        check("cnt_wrap", {24'h0, key_count}, 32'h0);
        check("sb_final", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
